// File: rtl/countdown_timer.sv
// countdown_timer: minutes:seconds countdown driven by a game FSM.
//
// Loads START_MIN:START_SEC, counts down once per CLK_FREQ clock cycles
// while game_start is high, and reports expiry with a one-cycle time_up
// pulse followed by a held expired level. Dropping game_start aborts and
// reloads from any state.
//
// Optional feature: define COUNTDOWN_TIMER_PAUSE_EN to let pause freeze the
// countdown while in COUNT. Without it the pause port is present but ignored.
//
// Ports:
//   Clock                     single clock, rising edge
//   reset                     synchronous, active-high
//   game_start                1 = run, 0 = abort and reload
//   pause                     freeze request (only with the pause feature)
//   sec_ones/sec_tens/minutes BCD remaining time
//   HEX0/HEX1/HEX2            active-low 7-segment images of the digits
//   running                   high while in COUNT
//   time_up                   one-cycle pulse on entering EXPIRED
//   expired                   high while in EXPIRED
//
// Handshake: none; game_start is a level, not a valid/ready pair.
module countdown_timer #(
  parameter int CLK_FREQ  = 50000000,
  parameter int START_MIN = 1,
  parameter int START_SEC = 0
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic       game_start,
  input  logic       pause,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] minutes,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic       running,
  output logic       time_up,
  output logic       expired
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] LAST = PW'(CLK_FREQ - 1);
  localparam logic [3:0] L_MIN  = 4'(START_MIN);
  localparam logic [3:0] L_TENS = 4'(START_SEC / 10);
  localparam logic [3:0] L_ONES = 4'(START_SEC % 10);
  localparam logic L_ZERO = (START_MIN == 0) && (START_SEC == 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0] r_presc;
  logic [3:0]    r_ones, r_tens, r_min;
  logic          r_time_up;

  logic          w_freeze;
  logic          w_tick;
  logic          w_last_sec;
  logic [3:0]    w_nxt_ones, w_nxt_tens, w_nxt_min;

`ifdef COUNTDOWN_TIMER_PAUSE_EN
  assign w_freeze = pause && (r_state == S_COUNT);
`else
  logic w_unused;
  assign w_unused = pause;
  assign w_freeze = 1'b0;
`endif

  assign w_tick     = (r_state == S_COUNT) && !w_freeze && (r_presc == LAST);
  // The tick taken at 0:01 is the one that produces 0:00.
  assign w_last_sec = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd1);

  // BCD decrement with borrow chain ones -> tens -> minutes.
  always_comb begin
    w_nxt_ones = r_ones - 4'd1;
    w_nxt_tens = r_tens;
    w_nxt_min  = r_min;
    if (r_ones == 4'd0) begin
      w_nxt_ones = 4'd9;
      if (r_tens == 4'd0) begin
        w_nxt_tens = 4'd5;
        w_nxt_min  = r_min - 4'd1;
      end else begin
        w_nxt_tens = r_tens - 4'd1;
      end
    end
  end

  // State register
  always_ff @(posedge Clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; game_start=0 wins over a simultaneous tick.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (game_start) w_next = L_ZERO ? S_EXPIRED : S_COUNT;
      end
      S_COUNT: begin
        if (!game_start)                w_next = S_IDLE;
        else if (w_tick && w_last_sec)  w_next = S_EXPIRED;
      end
      S_EXPIRED: begin
        if (!game_start) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: prescaler, digits and the expiry pulse.
  always_ff @(posedge Clock) begin
    if (reset) begin
      r_presc   <= '0;
      r_ones    <= L_ONES;
      r_tens    <= L_TENS;
      r_min     <= L_MIN;
      r_time_up <= 1'b0;
    end else begin
      r_time_up <= (r_state != S_EXPIRED) && (w_next == S_EXPIRED);
      if (w_next == S_IDLE || r_state == S_IDLE) begin
        // Covers abort/reload and the load on leaving IDLE.
        r_presc <= '0;
        r_ones  <= L_ONES;
        r_tens  <= L_TENS;
        r_min   <= L_MIN;
      end else if (r_state == S_COUNT && !w_freeze) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_tick) begin
          r_ones <= w_nxt_ones;
          r_tens <= w_nxt_tens;
          r_min  <= w_nxt_min;
        end
      end
    end
  end

  // Output logic
  always_comb begin
    running = (r_state == S_COUNT);
    expired = (r_state == S_EXPIRED);
  end

  assign time_up  = r_time_up;
  assign sec_ones = r_ones;
  assign sec_tens = r_tens;
  assign minutes  = r_min;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign HEX0 = seg7(r_ones);
  assign HEX1 = seg7(r_tens);
  assign HEX2 = seg7(r_min);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: three instances at CLK_FREQ=4 with load
// values 0:03 (main), 1:00 (minute borrow) and 0:00 (immediate expiry).
// Edge k below is the k-th rising edge after game_start is raised from IDLE.
module tb_countdown_timer;

  logic Clock = 1'b0;
  logic reset, pause;
  logic gs, gs_m, gs_z;

  logic [3:0] ones, tens, mins, ones_m, tens_m, mins_m, ones_z, tens_z, mins_z;
  logic [6:0] hex0, hex1, hex2, hex0_m, hex1_m, hex2_m, hex0_z, hex1_z, hex2_z;
  logic run, tup, expd, run_m, tup_m, expd_m, run_z, tup_z, expd_z;

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 Clock = ~Clock;

  countdown_timer #(.CLK_FREQ(4), .START_MIN(0), .START_SEC(3)) u_dut (
    .Clock(Clock), .reset(reset), .game_start(gs), .pause(pause),
    .sec_ones(ones), .sec_tens(tens), .minutes(mins),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2),
    .running(run), .time_up(tup), .expired(expd));

  countdown_timer #(.CLK_FREQ(4), .START_MIN(1), .START_SEC(0)) u_dut_m (
    .Clock(Clock), .reset(reset), .game_start(gs_m), .pause(pause),
    .sec_ones(ones_m), .sec_tens(tens_m), .minutes(mins_m),
    .HEX0(hex0_m), .HEX1(hex1_m), .HEX2(hex2_m),
    .running(run_m), .time_up(tup_m), .expired(expd_m));

  countdown_timer #(.CLK_FREQ(4), .START_MIN(0), .START_SEC(0)) u_dut_z (
    .Clock(Clock), .reset(reset), .game_start(gs_z), .pause(pause),
    .sec_ones(ones_z), .sec_tens(tens_z), .minutes(mins_z),
    .HEX0(hex0_z), .HEX1(hex1_z), .HEX2(hex2_z),
    .running(run_z), .time_up(tup_z), .expired(expd_z));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; gs = 1'b0; gs_m = 1'b0; gs_z = 1'b0; pause = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] digs();
    return {4'h0, mins, tens, ones};
  endfunction

  // Hand table: digits after edge k of a 0:03 countdown.
  function automatic logic [15:0] exp_digs(input int k);
    if (k < 5)       return 16'h003;
    else if (k < 9)  return 16'h002;
    else if (k < 13) return 16'h001;
    else             return 16'h000;
  endfunction

  // Expects u_dut in IDLE with gs about to be raised.
  task automatic run_countdown(input string tag);
    gs = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      check($sformatf("%s_digits_k%0d", tag, k), digs(), exp_digs(k));
      check($sformatf("%s_running_k%0d", tag, k), 16'(run), 16'(k < 13));
      check($sformatf("%s_timeup_k%0d", tag, k), 16'(tup), 16'(k == 13));
      check($sformatf("%s_expired_k%0d", tag, k), 16'(expd), 16'(k >= 13));
    end
  endtask

  initial begin : main
    int exp_at;
    int pulses;
    int exp_edge;
    logic [15:0] mid_exp;

    // reset state
    do_reset();
    check("rst_digits", digs(), 16'h003);
    check("rst_running", 16'(run), 16'h0);
    check("rst_timeup", 16'(tup), 16'h0);
    check("rst_expired", 16'(expd), 16'h0);
    check("rst_hex0", 16'(hex0), 16'(7'b0110000));
    check("rst_hex1", 16'(hex1), 16'(7'b1000000));
    check("rst_m_digits", {4'h0, mins_m, tens_m, ones_m}, 16'h100);
    check("rst_z_expired", 16'(expd_z), 16'h0);

    // basic countdown to expiry and hold
    run_countdown("basic");

    // abort at edge 10 then full restart
    do_reset();
    gs = 1'b1;
    repeat (10) step();
    check("abort_pre_digits", digs(), 16'h001);
    gs = 1'b0;
    step();
    check("abort_digits", digs(), 16'h003);
    check("abort_running", 16'(run), 16'h0);
    check("abort_expired", 16'(expd), 16'h0);
    run_countdown("restart");

    // expired holds until game_start drops
    gs = 1'b0;
    step();
    check("exp_drop_expired", 16'(expd), 16'h0);
    check("exp_drop_digits", digs(), 16'h003);

    // reset mid-count coinciding with a tick (tick due at edge 9)
    do_reset();
    gs = 1'b1;
    repeat (8) step();
    check("midrst_pre_digits", digs(), 16'h002);
    reset = 1'b1;
    step();
    check("midrst_digits", digs(), 16'h003);
    check("midrst_running", 16'(run), 16'h0);
    check("midrst_timeup", 16'(tup), 16'h0);
    check("midrst_expired", 16'(expd), 16'h0);
    reset = 1'b0;
    step();
    check("midrst_reenter_running", 16'(run), 16'h1);
    check("midrst_reenter_digits", digs(), 16'h003);

    // reset while expired, game_start held high
    do_reset();
    gs = 1'b1;
    repeat (14) step();
    check("exprst_pre_expired", 16'(expd), 16'h1);
    reset = 1'b1;
    step();
    check("exprst_expired", 16'(expd), 16'h0);
    check("exprst_digits", digs(), 16'h003);
    reset = 1'b0;
    step();
    check("exprst_running", 16'(run), 16'h1);

    // pause for 10 edges mid-count (edges 7..16)
    do_reset();
    gs = 1'b1;
    exp_at = 0;
    pulses = 0;
`ifdef COUNTDOWN_TIMER_PAUSE_EN
    exp_edge = 23;
    mid_exp  = 16'h002;
`else
    exp_edge = 13;
    mid_exp  = 16'h001;
`endif
    for (int k = 1; k <= 40; k++) begin
      pause = (k >= 7) && (k <= 16);
      step();
      if (k == 12) begin
        check("pause_mid_digits", digs(), mid_exp);
        check("pause_mid_running", 16'(run), 16'h1);
      end
      if (tup) pulses++;
      if (expd && exp_at == 0) exp_at = k;
    end
    pause = 1'b0;
    check("pause_expiry_edge", 16'(exp_at), 16'(exp_edge));
    check("pause_timeup_pulses", 16'(pulses), 16'h1);

    // minute borrow 1:00 -> 0:59
    do_reset();
    gs_m = 1'b1;
    repeat (4) step();
    check("min_pre_digits", {4'h0, mins_m, tens_m, ones_m}, 16'h100);
    check("min_pre_hex2", 16'(hex2_m), 16'(7'b1111001));
    step();
    check("min_digits", {4'h0, mins_m, tens_m, ones_m}, 16'h059);
    check("min_hex0", 16'(hex0_m), 16'(7'b0010000));
    check("min_hex1", 16'(hex1_m), 16'(7'b0010010));
    check("min_hex2", 16'(hex2_m), 16'(7'b1000000));
    check("min_running", 16'(run_m), 16'h1);

    // zero load: straight to EXPIRED with one pulse
    do_reset();
    gs_z = 1'b1;
    step();
    check("zero_expired", 16'(expd_z), 16'h1);
    check("zero_timeup", 16'(tup_z), 16'h1);
    check("zero_running", 16'(run_z), 16'h0);
    check("zero_hex", {2'b00, hex2_z[6:0], hex0_z[6:0]}, {2'b00, 7'b1000000, 7'b1000000});
    check("zero_hex1", 16'(hex1_z), 16'(7'b1000000));
    step();
    check("zero_timeup_once", 16'(tup_z), 16'h0);
    check("zero_hold_expired", 16'(expd_z), 16'h1);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
